// File: rtl/bcd_seg7_scan_if.sv
// Purpose : display bus between the BCD counter domain and the 7-segment scanner.
// Latency : n/a (signal bundle only).
// Backpr. : none; q is sampled freely, outputs are free-running.
// Signals : q[11:0] packed BCD (hundreds,tens,units), sel[2:0] active-low digit
//           enables, seg[7:0] active-low segments {dp,g..a}, frame_done pulse.
// Modports: master = producer of q / consumer of the display outputs,
//           slave  = the scanner itself.
interface bcd_seg7_scan_if;
   logic [11:0] q;
   logic [2:0]  sel;
   logic [7:0]  seg;
   logic        frame_done;

   modport master (
      output q,
      input  sel,
      input  seg,
      input  frame_done
   );

   modport slave (
      input  q,
      output sel,
      output seg,
      output frame_done
   );
endinterface

// File: rtl/bcd_seg7_scan.sv
// Purpose : multiplexed common-anode 3-digit 7-segment driver for a packed BCD value,
//           snapshotting the value once per frame so a frame never mixes two values.
// Latency : first digit (DIG0) shown SCAN_DIV cycles after reset release; each digit
//           dwells SCAN_DIV cycles; a new value is visible from the next frame start.
// Backpr. : none; the scan is free-running and the source is never stalled.
//
// Ports   : clk            system clock, rising edge
//           rst_n          asynchronous reset, active low (released synchronously upstream)
//           disp.q         packed BCD in: [3:0] units, [7:4] tens, [11:8] hundreds
//           disp.sel       digit enables, active low, sel[i] drives DIGi
//           disp.seg       segments, active low, [7]=dp (held off), [6:0]=g..a
//           disp.frame_done one-cycle pulse in the cycle a new snapshot is taken
// Config  : define LEADING_ZERO_BLANK_EN to blank leading zeros on DIG2/DIG1.
//           Undefined (default): every digit is always decoded.
// Params  : CLK_FREQ / SCAN_FREQ give SCAN_DIV, which must be at least 2.
module bcd_seg7_scan #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int SCAN_FREQ = 1_000
) (
   input  logic           clk,
   input  logic           rst_n,
   bcd_seg7_scan_if.slave disp
);

   // ------------------------------------------------------------------
   // Divider sizing
   // ------------------------------------------------------------------
   localparam int              SCAN_DIV = CLK_FREQ / SCAN_FREQ;
   localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // Digit index. DIG2 doubles as the reset state so the very first tick
   // behaves exactly like an end-of-frame tick and takes the first snapshot.
   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2
   } dig_e;

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] r_div;
   dig_e             r_idx;
   logic [11:0]      r_shadow;
   logic [2:0]       r_sel;
   logic [7:0]       r_seg;
   logic             r_frame_done;

   // ------------------------------------------------------------------
   // Combinational next-output path
   // ------------------------------------------------------------------
   logic        w_tick;
   logic        w_snap;
   dig_e        w_idx_nxt;
   logic [11:0] w_frame;
   logic [3:0]  w_nib;
   logic [2:0]  w_sel_nxt;
   logic        w_blank;
   logic [7:0]  w_seg_nxt;

   // Active-low segment pattern, dp off. Anything that is not a legal BCD
   // digit is shown as "E" so corrupted counter state is visible on the panel.
   function automatic logic [7:0] f_seg7(input logic [3:0] i_nib);
      logic [7:0] v;
      case (i_nib)
         4'd0:    v = 8'hC0;
         4'd1:    v = 8'hF9;
         4'd2:    v = 8'hA4;
         4'd3:    v = 8'hB0;
         4'd4:    v = 8'h99;
         4'd5:    v = 8'h92;
         4'd6:    v = 8'h82;
         4'd7:    v = 8'hF8;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h90;
         default: v = 8'h86;
      endcase
      return v;
   endfunction

   assign w_tick = (r_div == DIV_LAST);

   // Leaving DIG2 on a tick is the frame boundary: capture q.
   assign w_snap = w_tick && (r_idx == DIG2);

   // On the frame-boundary tick the shadow has not been loaded yet, so the
   // DIG0 decode taken in that same edge reads the live input instead.
   assign w_frame = (r_idx == DIG2) ? disp.q : r_shadow;

   always_comb begin
      w_idx_nxt = DIG0;
      case (r_idx)
         DIG0:    w_idx_nxt = DIG1;
         DIG1:    w_idx_nxt = DIG2;
         DIG2:    w_idx_nxt = DIG0;
         default: w_idx_nxt = DIG0;
      endcase
   end

   always_comb begin
      w_nib     = 4'd0;
      w_sel_nxt = 3'b111;
      case (w_idx_nxt)
         DIG0: begin
            w_nib     = w_frame[3:0];
            w_sel_nxt = 3'b110;
         end
         DIG1: begin
            w_nib     = w_frame[7:4];
            w_sel_nxt = 3'b101;
         end
         DIG2: begin
            w_nib     = w_frame[11:8];
            w_sel_nxt = 3'b011;
         end
         default: begin
            w_nib     = 4'd0;
            w_sel_nxt = 3'b111;
         end
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Only a nibble that is exactly zero counts as a leading zero; an illegal
   // nibble is treated as significant so the "E" is never hidden. DIG0 always
   // shows, so a value of 000 reads as a single 0.
   always_comb begin
      w_blank = 1'b0;
      case (w_idx_nxt)
         DIG2:    w_blank = (w_frame[11:8] == 4'd0);
         DIG1:    w_blank = (w_frame[11:8] == 4'd0) && (w_frame[7:4] == 4'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_seg_nxt = w_blank ? 8'hFF : f_seg7(w_nib);

   // ------------------------------------------------------------------
   // Divider, scan FSM and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div        <= '0;
         r_idx        <= DIG2;
         r_shadow     <= 12'h000;
         r_sel        <= 3'b111;
         r_seg        <= 8'hFF;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_tick) begin
            r_div <= '0;
            r_idx <= w_idx_nxt;
            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
            if (w_snap) begin
               r_shadow     <= disp.q;
               r_frame_done <= 1'b1;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign disp.sel        = r_sel;
   assign disp.seg        = r_seg;
   assign disp.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Purpose : scoreboard bench for bcd_seg7_scan (SCAN_DIV=10) with directed and random q.
// Latency : expected outputs derived from edges since reset release.
// Backpr. : none.
module tb_bcd_seg7_scan;
   localparam int DIV = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bcd_seg7_scan_if dif ();

   bcd_seg7_scan #(
      .CLK_FREQ (1000),
      .SCAN_FREQ(100)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .disp (dif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] seg;
      logic       fd;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          n_fd  = 0;
   int          k     = 0;        // rising edges since reset release
   logic [11:0] snap  = 12'h000;  // value the current frame displays
   logic [7:0]  seg_tab [0:15];

   initial begin
      seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
      seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
      seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
      for (int i = 10; i < 16; i++) seg_tab[i] = 8'h86;
   end

   // Reference timeline: digit slot n (n>=0) starts at edge (n+1)*DIV, digit n%3,
   // and every slot with digit 0 begins a frame that captures q at that edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         k = 0;
      end else begin
         k = k + 1;
         if (k >= DIV && (k % DIV) == 0 && ((k / DIV - 1) % 3) == 0)
            snap = dif.q;
      end
   end

   function automatic exp_t model_out();
      exp_t        e;
      int          d;
      logic [11:0] t;
      logic        blank;
      e.sel = 3'b111;
      e.seg = 8'hFF;
      e.fd  = 1'b0;
      if (rst_n && k >= DIV) begin
         d     = (k / DIV - 1) % 3;
         t     = snap >> (4 * d);
         blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         if (d == 2) blank = (snap[11:8] == 4'd0);
         if (d == 1) blank = (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0);
`endif
         e.sel = ~(3'b001 << d);
         e.seg = blank ? 8'hFF : seg_tab[t[3:0]];
         e.fd  = ((k % DIV) == 0) && (d == 0);
      end
      return e;
   endfunction

   // Producer: one expectation per cycle.
   always @(negedge clk) exp_q.push_back(model_out());

   // Monitor: pops and compares shortly after the falling edge.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if ({dif.sel, dif.seg, dif.frame_done} !== e) begin
            bad++;
            $display("FAIL scan t=%0t k=%0d got sel=%b seg=%h fd=%b want sel=%b seg=%h fd=%b",
                     $time, k, dif.sel, dif.seg, dif.frame_done, e.sel, e.seg, e.fd);
         end
         if (dif.frame_done === 1'b1) n_fd++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bounded wait for a given digit to become active.
   task automatic wait_sel(input logic [2:0] target);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (dif.sel === target) begin
            hit = 1'b1;
            break;
         end
         cyc(1);
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL wait_sel timeout got sel=%b want sel=%b", dif.sel, target);
      end
   endtask

   initial begin
      logic [11:0] r;
      dif.q = 12'h000;
      rst_n = 1'b0;
      cyc(5);
      rst_n = 1'b1;
      cyc(40);                       // power-up latency, q=000
      dif.q = 12'h123;
      cyc(95);                       // steady 123
      wait_sel(3'b101);
      dif.q = 12'h456;               // mid-frame change, must not tear
      cyc(70);
      dif.q = 12'h0A5;
      cyc(70);
      dif.q = 12'h007;
      cyc(70);
      dif.q = 12'h000;
      cyc(70);
      dif.q = 12'h123;
      wait_sel(3'b101);
      rst_n = 1'b0;                  // reset mid-frame
      cyc(3);
      rst_n = 1'b1;
      cyc(50);

      for (int it = 0; it < 30; it++) begin
         r = 12'($urandom);
         case ($urandom_range(0, 3))
            0:       r[11:8] = 4'd0;
            1:       r[11:4] = 8'd0;
            default: ;
         endcase
         dif.q = r;
         cyc($urandom_range(3, 50));
         if ($urandom_range(0, 9) == 0) begin
            rst_n = 1'b0;
            cyc($urandom_range(1, 4));
            rst_n = 1'b1;
         end
      end
      cyc(2);

      total++;
      if (n_fd < 10) begin
         bad++;
         $display("FAIL frame_count got %0d want at least 10", n_fd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
